// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults for the UART receive FIFO and its helpers.
package uart_rx_fifo_pkg;
  localparam int DW_DEF       = 8;
  localparam int DEPTH_DEF    = 16;
  localparam int AFULL_TH_DEF = 12;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte handshake bundle: upstream push from uart_rx, downstream FWFT pop to ram_rw.
interface uart_rx_fifo_if #(parameter int DW = 8);
  logic [DW-1:0] in_data_i;
  logic          in_vld_i;
  logic          in_rdy_o;
  logic [DW-1:0] out_data_o;
  logic          out_vld_o;
  logic          out_rdy_i;

  modport slave (
    input  in_data_i, in_vld_i, out_rdy_i,
    output in_rdy_o, out_data_o, out_vld_o
  );

  modport master (
    output in_data_i, in_vld_i, out_rdy_i,
    input  in_rdy_o, out_data_o, out_vld_o
  );
endinterface

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x DW register array, one write port, combinational read port.
module fifo_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between uart_rx and ram_rw: FWFT output, level, almost-full, sticky overrun.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AFULL_TH = AFULL_TH_DEF,
  localparam int AW      = $clog2(DEPTH),
  localparam int LW      = AW + 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  uart_rx_fifo_if.slave   bus,
  output logic [LW-1:0]   level_o,
  output logic            afull_o,
  output logic            ovf_o
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          ovf;
  logic          full, empty, push, pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  // Flush discards any transfer requested in the same cycle.
  assign push  = bus.in_vld_i & ~full & ~flush_i;
  assign pop   = bus.out_rdy_i & ~empty & ~flush_i;

  assign bus.in_rdy_o  = ~full;
  assign bus.out_vld_o = ~empty;
  assign level_o       = level;
  assign afull_o       = (level >= LW'(AFULL_TH));
  assign ovf_o         = ovf;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (bus.in_vld_i && full) ovf <= 1'b1;
    end
  end

  fifo_mem #(.DW(DW), .DEPTH(DEPTH)) u_mem (
    .clk_i (clk_i),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.in_data_i),
    .raddr (rd_ptr),
    .rdata (bus.out_data_o)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset, single byte, fill/overrun, flush, wrap, full+pop.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst_n, flush;
  logic [4:0] level;
  logic       afull, ovf;
  int chk = 0, pass = 0;

  uart_rx_fifo_if #(.DW(8)) bus ();

  uart_rx_fifo #(.DW(8), .DEPTH(16), .AFULL_TH(12)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .bus     (bus.slave),
    .level_o (level),
    .afull_o (afull),
    .ovf_o   (ovf)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    bus.in_vld_i = 1'b0; bus.in_data_i = '0; bus.out_rdy_i = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk++; if (bus.in_rdy_o !== 1'b1) $display("FAIL reset_in_rdy got %b exp 1", bus.in_rdy_o); else pass++;
    chk++; if (bus.out_vld_o !== 1'b0) $display("FAIL reset_out_vld got %b exp 0", bus.out_vld_o); else pass++;
    chk++; if (level !== 5'd0) $display("FAIL reset_level got %0d exp 0", level); else pass++;
    chk++; if (afull !== 1'b0) $display("FAIL reset_afull got %b exp 0", afull); else pass++;
    chk++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ovf); else pass++;
  endtask

  task automatic test_single();
    bus.in_vld_i = 1'b1; bus.in_data_i = 8'hA5;
    step();
    bus.in_vld_i = 1'b0;
    chk++; if (bus.out_vld_o !== 1'b1) $display("FAIL single_vld got %b exp 1", bus.out_vld_o); else pass++;
    chk++; if (bus.out_data_o !== 8'hA5) $display("FAIL single_data got %h exp a5", bus.out_data_o); else pass++;
    chk++; if (level !== 5'd1) $display("FAIL single_level got %0d exp 1", level); else pass++;
    bus.out_rdy_i = 1'b1;
    step();
    bus.out_rdy_i = 1'b0;
    chk++; if (level !== 5'd0) $display("FAIL single_pop_level got %0d exp 0", level); else pass++;
    chk++; if (bus.out_vld_o !== 1'b0) $display("FAIL single_pop_vld got %b exp 0", bus.out_vld_o); else pass++;
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < 16; i++) begin
      bus.in_vld_i = 1'b1; bus.in_data_i = 8'(i);
      step();
      chk++; if (level !== 5'(i+1)) $display("FAIL fill_level[%0d] got %0d exp %0d", i, level, i+1); else pass++;
      chk++; if (afull !== (i+1 >= 12)) $display("FAIL fill_afull[%0d] got %b exp %b", i, afull, (i+1 >= 12)); else pass++;
      chk++; if (bus.in_rdy_o !== (i+1 != 16)) $display("FAIL fill_in_rdy[%0d] got %b exp %b", i, bus.in_rdy_o, (i+1 != 16)); else pass++;
    end
    chk++; if (ovf !== 1'b0) $display("FAIL fill_ovf_pre got %b exp 0", ovf); else pass++;
    bus.in_data_i = 8'hFF;
    step(); step();
    bus.in_vld_i = 1'b0;
    chk++; if (ovf !== 1'b1) $display("FAIL ovf_set got %b exp 1", ovf); else pass++;
    chk++; if (level !== 5'd16) $display("FAIL ovf_level got %0d exp 16", level); else pass++;
    bus.out_rdy_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk++; if (bus.out_vld_o !== 1'b1 || bus.out_data_o !== 8'(i))
        $display("FAIL drain[%0d] got vld=%b data=%h exp vld=1 data=%h", i, bus.out_vld_o, bus.out_data_o, 8'(i)); else pass++;
      step();
    end
    bus.out_rdy_i = 1'b0;
    chk++; if (bus.out_vld_o !== 1'b0) $display("FAIL drain_empty got %b exp 0", bus.out_vld_o); else pass++;
    chk++; if (ovf !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", ovf); else pass++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) begin
      bus.in_vld_i = 1'b1; bus.in_data_i = 8'h60 + 8'(i);
      step();
    end
    chk++; if (level !== 5'd7 || ovf !== 1'b1) $display("FAIL flush_pre got level=%0d ovf=%b exp 7/1", level, ovf); else pass++;
    flush = 1'b1; bus.in_data_i = 8'h77; bus.out_rdy_i = 1'b1;
    step();
    flush = 1'b0; bus.in_vld_i = 1'b0; bus.out_rdy_i = 1'b0;
    chk++; if (level !== 5'd0) $display("FAIL flush_level got %0d exp 0", level); else pass++;
    chk++; if (ovf !== 1'b0) $display("FAIL flush_ovf got %b exp 0", ovf); else pass++;
    chk++; if (bus.out_vld_o !== 1'b0) $display("FAIL flush_vld got %b exp 0", bus.out_vld_o); else pass++;
    chk++; if (bus.in_rdy_o !== 1'b1) $display("FAIL flush_in_rdy got %b exp 1", bus.in_rdy_o); else pass++;
    step();
    chk++; if (level !== 5'd0) $display("FAIL flush_nostore got %0d exp 0", level); else pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      bus.in_vld_i = 1'b1; bus.in_data_i = 8'h40 + 8'(i);
      step();
    end
    bus.out_rdy_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.in_data_i = 8'h45 + 8'(k);
      chk++; if (bus.out_data_o !== 8'h40 + 8'(k)) $display("FAIL b2b_data[%0d] got %h exp %h", k, bus.out_data_o, 8'h40 + 8'(k)); else pass++;
      step();
      chk++; if (level !== 5'd5) $display("FAIL b2b_level[%0d] got %0d exp 5", k, level); else pass++;
    end
    bus.in_vld_i = 1'b0; bus.out_rdy_i = 1'b0;
  endtask

  task automatic test_full_pop();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.in_vld_i = 1'b1; bus.in_data_i = 8'h80 + 8'(i);
      step();
    end
    chk++; if (level !== 5'd16) $display("FAIL fp_full got %0d exp 16", level); else pass++;
    bus.in_data_i = 8'hEE; bus.out_rdy_i = 1'b1;
    step();
    bus.out_rdy_i = 1'b0;
    chk++; if (level !== 5'd15) $display("FAIL fp_pop_only got %0d exp 15", level); else pass++;
    chk++; if (bus.out_data_o !== 8'h81) $display("FAIL fp_head got %h exp 81", bus.out_data_o); else pass++;
    chk++; if (ovf !== 1'b1) $display("FAIL fp_ovf got %b exp 1", ovf); else pass++;
    step();
    bus.in_vld_i = 1'b0;
    chk++; if (level !== 5'd16) $display("FAIL fp_push_next got %0d exp 16", level); else pass++;
    bus.out_rdy_i = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk++; if (bus.out_data_o !== 8'h80 + 8'(i)) $display("FAIL fp_drain[%0d] got %h exp %h", i, bus.out_data_o, 8'h80 + 8'(i)); else pass++;
      step();
    end
    chk++; if (bus.out_vld_o !== 1'b1 || bus.out_data_o !== 8'hEE) $display("FAIL fp_tail got vld=%b data=%h exp 1/ee", bus.out_vld_o, bus.out_data_o); else pass++;
    step();
    bus.out_rdy_i = 1'b0;
    chk++; if (bus.out_vld_o !== 1'b0) $display("FAIL fp_empty got %b exp 0", bus.out_vld_o); else pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overrun();
    test_flush();
    test_back_to_back();
    test_full_pop();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
